// File: rtl/zclk_sched_pkg.sv
// Shared types and constants for the Z80 clock sequencer and its slot decoder.
package zclk_sched_pkg;

    typedef logic [1:0] turbo_t;

    // turbo_req / turbo_cur encodings; 2'b11 also selects 14 MHz
    localparam turbo_t TURBO_3M5 = 2'b00;
    localparam turbo_t TURBO_7M  = 2'b01;
    localparam turbo_t TURBO_14M = 2'b10;

    localparam int unsigned StallCntW = 8;

    typedef enum logic [1:0] {
        Mode3m5,
        Mode7m,
        Mode14m
    } mode_e;

    // Any value with bit 1 set selects 14 MHz.
    function automatic mode_e turbo_to_mode(turbo_t t);
        if (t[1]) begin
            return Mode14m;
        end else if (t[0]) begin
            return Mode7m;
        end
        return Mode3m5;
    endfunction

endpackage

// File: rtl/zclk_sched_if.sv
// Phase strobes, mode/wait requests and CPU clock outputs of the clock sequencer.
interface zclk_sched_if;
    import zclk_sched_pkg::*;

    logic   c0;
    logic   c1;
    logic   c2;
    logic   c3;
    turbo_t turbo_req;
    logic   wait_req;
    logic   zclk;
    logic   zpos;
    logic   zneg;
    turbo_t turbo_cur;
    logic   stalled;
    logic   wait_tmo;

    modport master (
        output c0, c1, c2, c3, turbo_req, wait_req,
        input  zclk, zpos, zneg, turbo_cur, stalled, wait_tmo
    );

    modport slave (
        input  c0, c1, c2, c3, turbo_req, wait_req,
        output zclk, zpos, zneg, turbo_cur, stalled, wait_tmo
    );

endinterface

// File: rtl/zclk_slot_dec.sv
// Natural CPU clock edge slots for the current 7 MHz phase and turbo mode.
// Purely combinational so the memory arbiter can reuse it to predict CPU edges.
module zclk_slot_dec
    import zclk_sched_pkg::*;
(
    input  logic   c0,
    input  logic   c1,
    input  logic   c2,
    input  logic   c3,
    input  logic   ph,
    input  turbo_t mode,
    output logic   pos_slot,
    output logic   neg_slot
);

    // Decode rising/falling slot for this clk from phase strobe, ph and mode
    always_comb begin
        pos_slot = 1'b0;
        neg_slot = 1'b0;
        unique case (turbo_to_mode(mode))
            Mode14m: begin
                pos_slot = c0 | c2;
                neg_slot = c1 | c3;
            end
            Mode7m: begin
                pos_slot = c0;
                neg_slot = c2;
            end
            Mode3m5: begin
                pos_slot = c0 & ~ph;
                neg_slot = c0 & ph;
            end
            default: begin
                pos_slot = 1'b0;
                neg_slot = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/zclk_sched.sv
// Z80 clock sequencer: turbo mode latch, edge strobe generation, wait parking
// and stall watchdog.
module zclk_sched
    import zclk_sched_pkg::*;
#(
    parameter turbo_t      TURBO_RST = TURBO_3M5,
    parameter int unsigned WAIT_MAX  = 255
) (
    input  logic         clk,
    input  logic         rst,
    zclk_sched_if.slave  bus
);

    localparam logic [StallCntW-1:0] WaitMaxC = StallCntW'(WAIT_MAX);
    localparam logic [StallCntW-1:0] CntSat   = '1;

    logic                 ph_q, ph_d;
    turbo_t               cur_q, cur_d;
    logic                 zclk_q, zclk_d;
    logic                 zpos_q, zpos_d;
    logic                 zneg_q, zneg_d;
    logic                 stalled_q, stalled_d;
    logic                 tmo_q, tmo_d;
    logic [StallCntW-1:0] cnt_q, cnt_d;

    logic   at_a;
    turbo_t slot_mode;
    logic   pos_slot;
    logic   neg_slot;

    // Aligned point: the new mode already drives slot decoding in this cycle
    always_comb begin
        at_a      = bus.c0 & ~ph_q;
        slot_mode = at_a ? bus.turbo_req : cur_q;
    end

    zclk_slot_dec u_slot_dec (
        .c0       (bus.c0),
        .c1       (bus.c1),
        .c2       (bus.c2),
        .c3       (bus.c3),
        .ph       (ph_q),
        .mode     (slot_mode),
        .pos_slot (pos_slot),
        .neg_slot (neg_slot)
    );

    // Next-state: strobes gated by the level the clock will hold once pending strobes land
    always_comb begin
        ph_d   = ph_q ^ bus.c3;
        cur_d  = slot_mode;
        zclk_d = zclk_q;
        if (zpos_q) begin
            zclk_d = 1'b1;
        end else if (zneg_q) begin
            zclk_d = 1'b0;
        end
        // zclk_d low also implies no zpos is pending
        zpos_d = pos_slot & ~bus.wait_req & ~zclk_d;
        zneg_d = neg_slot & zclk_d;

        stalled_d = stalled_q;
        if (zpos_d) begin
            stalled_d = 1'b0;
        end else if (pos_slot && bus.wait_req) begin
            stalled_d = 1'b1;
        end

        // Count includes the current stalled cycle, saturating
        cnt_d = '0;
        if (stalled_d) begin
            cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
        end
        tmo_d = stalled_d & (cnt_d >= WaitMaxC);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q      <= 1'b0;
            cur_q     <= TURBO_RST;
            zclk_q    <= 1'b0;
            zpos_q    <= 1'b0;
            zneg_q    <= 1'b0;
            stalled_q <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ph_q      <= ph_d;
            cur_q     <= cur_d;
            zclk_q    <= zclk_d;
            zpos_q    <= zpos_d;
            zneg_q    <= zneg_d;
            stalled_q <= stalled_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs straight from registers
    always_comb begin
        bus.zclk      = zclk_q;
        bus.zpos      = zpos_q;
        bus.zneg      = zneg_q;
        bus.turbo_cur = cur_q;
        bus.stalled   = stalled_q;
        bus.wait_tmo  = tmo_q;
    end

endmodule

// File: doc/zclk_sched.md
Name: zclk_sched

Overview:
- CPU clock sequencer driven by the 28 MHz clock and the c0..c3 quarter-phase strobes of the 7 MHz cycle.
- Generates the Z80 clock level plus one-cycle-early edge strobes (zpos/zneg) for 3.5, 7 and 14 MHz turbo modes.
- Turbo changes take effect only at a common aligned edge, so the CPU clock never glitches.
- Memory/DMA arbitration can park the CPU clock low through a wait request; a watchdog flags over-long stalls.

Parameters:
- TURBO_RST, 2'b00, turbo mode loaded at reset.
- WAIT_MAX, 255, stall length in clk cycles after which wait_tmo asserts (1..255).

Ports:
- clk  in  1  28 MHz system clock
- rst  in  1  synchronous reset, active-high
- c0  in  1  phase strobe, 7 MHz cycle slot 0
- c1  in  1  phase strobe, slot 1
- c2  in  1  phase strobe, slot 2
- c3  in  1  phase strobe, slot 3
- turbo_req  in  2  requested mode: 00 = 3.5 MHz, 01 = 7 MHz, 1x = 14 MHz
- wait_req  in  1  hold CPU clock low (suppress zpos)
- zclk  out  1  CPU clock level
- zpos  out  1  one-clk strobe; zclk rises on the next clk edge
- zneg  out  1  one-clk strobe; zclk falls on the next clk edge
- turbo_cur  out  2  mode currently in effect
- stalled  out  1  a zpos slot was suppressed and the clock is parked low
- wait_tmo  out  1  stall has lasted at least WAIT_MAX clks

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all state is on posedge clk.
- Exactly one of c0..c3 is high per clk, rotating c0→c1→c2→c3. Non-one-hot input is undefined.
- Internal ph (1 bit) toggles on each c3 cycle. It marks even/odd 7 MHz cycles.
- Reset state: zclk=0, zpos=0, zneg=0, ph=0, turbo_cur=TURBO_RST, stalled=0, wait_tmo=0, stall counter=0.
- Aligned point A = c0 & ~ph. In the A cycle: turbo_cur <= turbo_req. Slot decoding in that cycle already uses turbo_req.
  - At A, every mode places zpos and zclk is already low, so switching is glitch-free.
  - turbo_req changes outside A are ignored until the next A (latency ≤ 8 clks).
- Natural slots, combinational from the current c/ph/mode, registered into zpos/zneg:
  - 14 MHz: pos at c0 and c2; neg at c1 and c3.
  - 7 MHz: pos at c0; neg at c2.
  - 3.5 MHz: pos at c0&~ph; neg at c0&ph.
- zpos/zneg are registered: they are high in the clk cycle after the slot cycle. zclk updates on the following edge (zclk <= 1 on zpos, 0 on zneg). Slot-to-zclk latency is 2 clks.
- zpos is never issued while zclk=1 (or while zpos is already pending); zneg is never issued while zclk=0. Each such strobe is dropped.
- Wait handling:
  - wait_req=1 in a pos-slot cycle suppresses that zpos and sets stalled=1.
  - Neg slots are always honoured, so the clock parks low.
  - stalled clears when the next zpos issues.
  - On wait_req release, the first natural pos slot of the current mode issues zpos. There are no catch-up edges.
- Stall counter:
  - Counts clks while stalled=1, saturating at 255.
  - wait_tmo=1 when count ≥ WAIT_MAX.
  - Counter and wait_tmo clear in the cycle stalled clears.
- Mode change during a stall: still applied at A. The resume edge then follows the new mode's slots.
- Reset mid-operation (including mid-high zclk) forces the reset state on the next edge. The first zpos occurs only after the first A or mode slot.

Decomposition:
- Shared package holds mode constants TURBO_3M5=2'b00, TURBO_7M=2'b01, TURBO_14M=2'b10.
- Natural sub-module: zclk_slot_dec. It is purely combinational: c0..c3, ph, mode → pos_slot, neg_slot. It is reused by the memory arbiter to predict CPU edges.
- Stall counter and mode latch stay in zclk_sched.

Test Plan:
- Reset, turbo_req=00, wait_req=0, run 64 clks → zclk period 8 clks, 4 high / 4 low; zpos one clk after each c0&~ph cycle; turbo_cur=00.
- turbo_req=10 held → zclk period 2 clks; 7 MHz (01) → period 4, 50 % duty.
- Switch 00→10 mid-cycle (at ph=1,c2) → turbo_cur changes only at the next c0&~ph; no zclk high or low pulse shorter than 1 clk around the change.
- 7 MHz, wait_req=1 for 12 clks starting at a c0 → zclk parks low after the pending zneg; stalled=1; first zpos issues at the first c0 after release; stalled then 0.
- WAIT_MAX=5, wait_req held 20 clks → wait_tmo rises on the 5th stalled clk; clears with stalled at resume.
- rst pulsed while zclk=1 in 14 MHz → zclk=0 and turbo_cur=TURBO_RST next edge; clean restart at the first slot.
